// File: rtl/ic74hc_pkg.sv
// ic74hc_pkg: shared definitions for the IC74HC151 time-division link.
//   state_t : receive FSM encoding (IDLE, HUNT, RUN)
//   LANES   : default lanes per frame, matching the IC74HC151 mux DATA_IN
package ic74hc_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HUNT = 2'd1,
      RUN  = 2'd2
   } state_t;
   localparam int LANES = 8;
endpackage

// File: rtl/ic74hc_tdm_demux_chan_cnt.sv
// chan_cnt: mod-N lane counter that drives the remote mux select lines.
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : force count to 0 (highest priority after rst)
//   i_ld1    : load 1 (a lane 0 bit was just taken)
//   i_en     : advance, wrapping from N-1 to 0
//   o_cnt    : current lane index
//   o_last   : high while o_cnt is the last lane
module chan_cnt #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_ld1,
   input  logic         i_en,
   output logic [W-1:0] o_cnt,
   output logic         o_last
);
   logic [W-1:0] r_cnt;
   logic         w_last;
   assign w_last = r_cnt == W'(N - 1);
   always_ff @(posedge clk)
      if (rst || i_clr) r_cnt <= '0;
      else if (i_ld1)   r_cnt <= W'(1);
      else if (i_en)    r_cnt <= w_last ? '0 : r_cnt + W'(1);
   assign o_cnt  = r_cnt;
   assign o_last = w_last;
endmodule

// File: rtl/ic74hc_tdm_demux.sv
// ic74hc_tdm_demux: receive end of the IC74HC151 8:1 TDM link; deserialises y_in into dout.
//   clk, rst   : clock, synchronous active-high reset
//   E          : active-high disable, forces IDLE
//   sync       : frame marker, high with lane 0's bit
//   y_in       : serial bit from the remote mux
//   sel        : lane index expected on y_in this cycle
//   dout       : last complete frame, bit i = lane i
//   dout_valid : one-cycle pulse when dout updates
//   frame_err  : one-cycle pulse on a sync protocol violation
module ic74hc_tdm_demux
   import ic74hc_pkg::*;
#(
   parameter  int DATA_OUT = LANES,
   localparam int SEL_W    = $clog2(DATA_OUT)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                E,
   input  logic                sync,
   input  logic                y_in,
   output logic [SEL_W-1:0]    sel,
   output logic [DATA_OUT-1:0] dout,
   output logic                dout_valid,
   output logic                frame_err
);
   state_t                r_state, w_next;
   logic [DATA_OUT-2:0]   r_shadow;
   logic [DATA_OUT-1:0]   r_dout;
   logic                  r_valid, r_err;
   logic [SEL_W-1:0]      w_sel;
   logic                  w_last, w_run, w_ld1, w_clr, w_inc, w_err, w_done, w_wr;
   chan_cnt #(.N(DATA_OUT), .W(SEL_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_clr),
      .i_ld1  (w_ld1),
      .i_en   (w_inc),
      .o_cnt  (w_sel),
      .o_last (w_last)
   );
   always_ff @(posedge clk)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   always_comb
      w_next = E                 ? IDLE :
               r_state == IDLE   ? HUNT :
               r_state == HUNT   ? (sync ? RUN : HUNT) :
               r_state == RUN    ? ((!sync && w_sel == '0) ? HUNT : RUN) :
                                   IDLE;
   // Any sync in HUNT/RUN takes the bit as lane 0; outside RUN the counter is held at 0.
   always_comb begin
      w_run  = !E && r_state == RUN;
      w_ld1  = !E && (r_state == HUNT || r_state == RUN) && sync;
      w_clr  = !w_run && !w_ld1;
      w_inc  = w_run && !sync && w_sel != '0;
      w_err  = w_run && (sync ? w_sel != '0 : w_sel == '0);
      w_done = w_inc && w_last;
      w_wr   = w_inc && !w_last;
   end
   // The last lane goes straight to dout, so the shadow only holds lanes 0..DATA_OUT-2.
   always_ff @(posedge clk)
      if (rst) begin
         r_shadow <= '0;
         r_dout   <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         for (int i = 0; i < DATA_OUT - 1; i++)
            if ((w_ld1 && i == 0) || (w_wr && w_sel == SEL_W'(i))) r_shadow[i] <= y_in;
         if (w_done) r_dout <= {y_in, r_shadow};
         r_valid <= w_done;
         r_err   <= w_err;
      end
   assign sel        = w_sel;
   assign dout       = r_dout;
   assign dout_valid = r_valid;
   assign frame_err  = r_err;
endmodule

// File: tb/tb_ic74hc_tdm_demux.sv
module tb_ic74hc_tdm_demux;
   localparam int N = 8;
   logic         clk = 0, rst = 1, E = 0, sync = 0, y_in = 0;
   logic [2:0]   sel;
   logic [N-1:0] dout;
   logic         dout_valid, frame_err;
   int           checks = 0, errors = 0;
   ic74hc_tdm_demux #(.DATA_OUT(N)) dut (
      .clk(clk), .rst(rst), .E(E), .sync(sync), .y_in(y_in),
      .sel(sel), .dout(dout), .dout_valid(dout_valid), .frame_err(frame_err)
   );
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: frame-level view of the link.
   bit           m_started = 0, m_idle = 1, m_locked = 0, m_valid = 0, m_err = 0;
   int           m_pos = 0;
   logic [N-1:0] m_bits = '0, m_dout = '0;
   always @(posedge clk) begin
      if (rst) begin
         m_started = 1; m_idle = 1; m_locked = 0; m_pos = 0;
         m_dout = '0; m_valid = 0; m_err = 0;
      end else begin
         m_valid = 0; m_err = 0;
         if (E) begin
            m_idle = 1; m_locked = 0; m_pos = 0;
         end else if (m_idle) m_idle = 0;
         else if (!m_locked) begin
            if (sync) begin m_bits[0] = y_in; m_pos = 1; m_locked = 1; end
         end else if (sync) begin
            m_err = m_pos != 0; m_bits[0] = y_in; m_pos = 1;
         end else if (m_pos == 0) begin
            m_err = 1; m_locked = 0;
         end else begin
            m_bits[m_pos] = y_in;
            m_pos++;
            if (m_pos == N) begin m_dout = m_bits; m_valid = 1; m_pos = 0; end
         end
      end
      #1;
      if (m_started) begin
         chk("sel", int'(sel), m_pos);
         chk("dout", int'(dout), int'(m_dout));
         chk("dout_valid", int'(dout_valid), int'(m_valid));
         chk("frame_err", int'(frame_err), int'(m_err));
         chk("valid_err_exclusive", int'(dout_valid & frame_err), 0);
      end
   end

   task automatic drive(input bit e, input bit s, input bit y);
      E = e; sync = s; y_in = y;
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) drive(0, i == 0, v[i]);
   endtask

   initial begin
      logic [N-1:0] v;
      @(negedge clk);
      @(negedge clk);
      chk("rst_sel", int'(sel), 0);
      chk("rst_dout", int'(dout), 0);
      chk("rst_valid", int'(dout_valid), 0);
      chk("rst_err", int'(frame_err), 0);
      rst = 0;
      drive(0, 0, 1);
      repeat (3) drive(0, 0, 1);
      chk("hunt_sel", int'(sel), 0);
      // lanes 0..7 = 1,0,1,1,0,0,1,0
      send_frame(8'h4D);
      chk("t2_dout", int'(dout), 8'h4D);
      chk("t2_valid", int'(dout_valid), 1);
      // back-to-back frames 8 cycles apart
      send_frame(8'hA5);
      chk("t3_a5", int'(dout), 8'hA5);
      chk("t3_a5_v", int'(dout_valid), 1);
      send_frame(8'h3C);
      chk("t3_3c", int'(dout), 8'h3C);
      chk("t3_3c_v", int'(dout_valid), 1);
      send_frame(8'hFF);
      chk("t3_ff", int'(dout), 8'hFF);
      chk("t3_ff_v", int'(dout_valid), 1);
      chk("t3_no_err", int'(frame_err), 0);
      // resync at sel=4
      for (int i = 0; i < 4; i++) drive(0, i == 0, 1);
      chk("t4_sel4", int'(sel), 4);
      v = 8'h69;
      drive(0, 1, v[0]);
      chk("t4_err", int'(frame_err), 1);
      chk("t4_sel1", int'(sel), 1);
      chk("t4_novalid", int'(dout_valid), 0);
      for (int i = 1; i < N; i++) drive(0, 0, v[i]);
      chk("t4_dout", int'(dout), 8'h69);
      chk("t4_valid", int'(dout_valid), 1);
      // missing sync at sel=0
      drive(0, 0, 1);
      chk("t5_err", int'(frame_err), 1);
      chk("t5_sel", int'(sel), 0);
      drive(0, 0, 0);
      drive(0, 0, 1);
      chk("t5_hunt_sel", int'(sel), 0);
      chk("t5_err_clear", int'(frame_err), 0);
      // disable on last lane
      send_frame(8'h4D);
      v = 8'hF0;
      for (int i = 0; i < N - 1; i++) drive(0, i == 0, v[i]);
      chk("t6_sel7", int'(sel), 7);
      drive(1, 0, v[7]);
      chk("t6_novalid", int'(dout_valid), 0);
      chk("t6_dout_hold", int'(dout), 8'h4D);
      chk("t6_sel0", int'(sel), 0);
      drive(1, 1, 1);
      chk("t6_idle_sel", int'(sel), 0);
      drive(0, 0, 0);
      send_frame(8'h5A);
      chk("t6_resume", int'(dout), 8'h5A);
      chk("t6_resume_v", int'(dout_valid), 1);
      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 11))
            0: repeat ($urandom_range(1, 3)) drive(1, $urandom_range(0, 1), $urandom_range(0, 1));
            1: drive(0, $urandom_range(0, 1), $urandom_range(0, 1));
            2: begin rst = 1; drive(0, $urandom_range(0, 1), 1); rst = 0; end
            3: for (int i = 0; i < N; i++)
                  drive($urandom_range(0, 15) == 0, i == 0 || $urandom_range(0, 7) == 0, $urandom_range(0, 1));
            default: send_frame(N'($urandom));
         endcase
      end
      drive(0, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
